io_out_fifo: RTL and testbench
==============================

Name: io_out_fifo

Overview:
- Downstream consumer of the processor top's output side; sits after the float2int converter and the output address decoder.
- Each cycle in which any out_en strobe is high, it captures the io_out word plus the index of the asserted port into a FIFO.
- The FIFO drains over a valid/ready stream to a slower sink (UART/DAC bridge).
- Decouples the processor's single-cycle output strobes from sink back-pressure, and counts every sample lost to overflow.

Parameters:
- DWID, 33, data width; matches the io_out width of the processor top.
- NUIOOU, 4, number of output ports; equals the width of out_en.
- PWID, 2, port-index width; must satisfy 2**PWID >= NUIOOU.
- DEPTH, 16, number of FIFO entries; power of two.
- AWID, 4, pointer width; log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- io_out  in  DWID  data word from the processor output path.
- out_en  in  NUIOOU  one-hot output strobes from the output address decoder.
- m_data  out  DWID  head-entry data.
- m_port  out  PWID  head-entry port index.
- m_valid  out  1  head entry is valid.
- m_ready  in  1  sink accepts the head entry.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AWID+1  current occupancy.
- ovf_cnt  out  16  dropped-sample counter; saturates at 16'hFFFF.
- multi_err  out  1  sticky flag: more than one out_en bit seen high in the same cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - write pointer, read pointer, count, ovf_cnt and multi_err all cleared to 0.
  - empty=1, full=0, m_valid=0; m_data and m_port driven 0 while empty.
  - Storage array contents are not reset.
  - Reset asserted mid-transfer discards all entries immediately, with no clock edge needed.
- push = |out_en. The captured port index is the lowest set bit of out_en. If popcount(out_en) > 1, multi_err is set and held until reset; the word is still pushed with the lowest index.
- Output is first-word fall-through:
  - m_valid = ~empty.
  - m_data and m_port show storage[rd_ptr] combinationally, valid in the same cycle the entry exists.
- pop = m_valid & m_ready. On the clock edge, rd_ptr increments.
- Push acceptance: a push is accepted when count < DEPTH, or when a pop happens in the same cycle. An accepted push writes {port, io_out} at wr_ptr, then wr_ptr increments.
- A rejected push (full and no pop) is dropped and ovf_cnt increments by 1, saturating at 65535. Storage is unchanged.
- Count update per cycle:
  - accepted push and no pop: count+1.
  - pop and no push: count-1.
  - both: count unchanged.
  - neither: count unchanged.
- m_ready while empty has no effect; pointers and count hold.
- Pointers wrap modulo DEPTH (natural AWID-bit rollover). Full vs empty is resolved by count, not by pointer comparison.
- Latency: a word pushed into an empty FIFO at edge N appears on m_data with m_valid=1 right after edge N, so it is poppable in cycle N+1.
- full, empty, count, ovf_cnt and multi_err are all registered or derived from registered count; there are no combinational paths from io_out to the status outputs.

Optional Feature:
- Macro: IO_OUT_FIFO_TSTAMP_EN.
- When defined:
  - A free-running 16-bit cycle counter is added; it resets to 0 and wraps from 65535 to 0.
  - Its value at the push edge is stored with each entry.
  - It is presented on an extra output port m_tstamp [15:0], aligned with m_data.
  - Storage width becomes DWID+PWID+16.
- When undefined: no counter, no m_tstamp port, and storage width is DWID+PWID.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then rst=1 -> empty=1, m_valid=0, count=0, ovf_cnt=0, multi_err=0.
- Single push: out_en=4'b0100, io_out=33'h0_0000_1234 for one cycle, m_ready=0 -> next cycle m_valid=1, m_data=33'h0_0000_1234, m_port=2, count=1. Then m_ready=1 for one cycle -> empty=1.
- Fill and overflow: 18 consecutive pushes of values 1..18 on port 0 with m_ready=0 -> full=1, count=16, ovf_cnt=2. Draining returns 1..16 in order; values 17 and 18 are absent.
- Simultaneous push/pop when full: full FIFO, m_ready=1 and out_en=4'b0001 with io_out=33'h99 -> count stays 16, ovf_cnt unchanged, and 33'h99 is the last word drained.
- Multi-hot strobe: out_en=4'b1010, io_out=33'h55 -> entry stored with m_port=1 and multi_err=1. multi_err stays 1 through 100 idle cycles and clears only on rst=0.
- Mid-operation reset: count=5, assert rst=0 between clock edges -> count=0, empty=1, m_valid=0 immediately. After release, the first push appears at rd_ptr 0 with the correct data.

Source files
------------

// File: rtl/io_out_fifo.sv
// rtl/io_out_fifo.sv - output-strobe capture FIFO with overflow counting (optional IO_OUT_FIFO_TSTAMP_EN)
module io_out_fifo #(
    parameter int DWID   = 33,
    parameter int NUIOOU = 4,
    parameter int PWID   = 2,
    parameter int DEPTH  = 16,
    parameter int AWID   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWID-1:0]   io_out,
    input  logic [NUIOOU-1:0] out_en,
    output logic [DWID-1:0]   m_data,
    output logic [PWID-1:0]   m_port,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              full,
    output logic              empty,
    output logic [AWID:0]     count,
    output logic [15:0]       ovf_cnt,
    output logic              multi_err
`ifdef IO_OUT_FIFO_TSTAMP_EN
    ,
    output logic [15:0]       m_tstamp
`endif
);

`ifdef IO_OUT_FIFO_TSTAMP_EN
    localparam int SWID = DWID + PWID + 16;
`else
    localparam int SWID = DWID + PWID;
`endif

    logic [SWID-1:0] mem [DEPTH];
    logic [AWID-1:0] wr_ptr;
    logic [AWID-1:0] rd_ptr;
    logic [PWID-1:0] port_idx;
    logic [SWID-1:0] entry;
    logic [SWID-1:0] head;
    logic            push;
    logic            pop;
    logic            accept;
    logic            multi_hot;

    // Lowest set strobe wins when several are high.
    always_comb begin
        port_idx = '0;
        for (int i = NUIOOU - 1; i >= 0; i--) begin
            if (out_en[i]) port_idx = PWID'(i);
        end
    end

    assign multi_hot = |(out_en & (out_en - NUIOOU'(1)));
    assign push      = |out_en;
    assign full      = (count == (AWID+1)'(DEPTH));
    assign empty     = (count == '0);
    assign m_valid   = ~empty;
    assign pop       = m_valid & m_ready;
    assign accept    = push & (~full | pop);

`ifdef IO_OUT_FIFO_TSTAMP_EN
    logic [15:0] tstamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tstamp <= '0;
        else      tstamp <= tstamp + 16'd1;
    end

    assign entry    = {tstamp, port_idx, io_out};
    assign m_tstamp = empty ? 16'd0 : head[SWID-1 -: 16];
`else
    assign entry = {port_idx, io_out};
`endif

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= entry;
    end

    assign head   = mem[rd_ptr];
    assign m_data = empty ? '0 : head[DWID-1:0];
    assign m_port = empty ? '0 : head[DWID+PWID-1:DWID];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_cnt   <= '0;
            multi_err <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AWID'(1);
            if (pop)    rd_ptr <= rd_ptr + AWID'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AWID+1)'(1);
                2'b01:   count <= count - (AWID+1)'(1);
                default: count <= count;
            endcase
            if (push && !accept && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            if (multi_hot) multi_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_out_fifo.sv
// tb/tb_io_out_fifo.sv - directed self-checking bench for io_out_fifo
module tb_io_out_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] io_out;
    logic [3:0]  out_en;
    logic [32:0] m_data;
    logic [1:0]  m_port;
    logic        m_valid;
    logic        m_ready;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic [15:0] ovf_cnt;
    logic        multi_err;
`ifdef IO_OUT_FIFO_TSTAMP_EN
    logic [15:0] m_tstamp;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    io_out_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .io_out    (io_out),
        .out_en    (out_en),
        .m_data    (m_data),
        .m_port    (m_port),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ovf_cnt   (ovf_cnt),
        .multi_err (multi_err)
`ifdef IO_OUT_FIFO_TSTAMP_EN
        ,
        .m_tstamp  (m_tstamp)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        io_out  = '0;
        out_en  = '0;
        m_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(ovf_cnt), 64'd0);
        check("rst_multi", 64'(multi_err), 64'd0);
        check("rst_mdata", 64'(m_data), 64'd0);

        out_en = 4'b0100;
        io_out = 33'h0_0000_1234;
        step();
        out_en = '0;
        check("single_valid", 64'(m_valid), 64'd1);
        check("single_data", 64'(m_data), 64'h1234);
        check("single_port", 64'(m_port), 64'd2);
        check("single_count", 64'(count), 64'd1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("single_drained", 64'(empty), 64'd1);

        for (int i = 1; i <= 18; i++) begin
            out_en = 4'b0001;
            io_out = 33'(i);
            step();
        end
        out_en = '0;
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd16);
        check("fill_ovf", 64'(ovf_cnt), 64'd2);
        check("fill_head", 64'(m_data), 64'd1);

        m_ready = 1'b1;
        out_en  = 4'b0001;
        io_out  = 33'h99;
        step();
        out_en = '0;
        check("pushpop_count", 64'(count), 64'd16);
        check("pushpop_ovf", 64'(ovf_cnt), 64'd2);
        for (int k = 2; k <= 16; k++) begin
            check($sformatf("drain_%0d", k), 64'(m_data), 64'(k));
            step();
        end
        check("drain_last", 64'(m_data), 64'h99);
        check("drain_last_valid", 64'(m_valid), 64'd1);
        step();
        check("drain_empty", 64'(empty), 64'd1);
        step();
        check("ready_empty_count", 64'(count), 64'd0);
        m_ready = 1'b0;

        out_en = 4'b1010;
        io_out = 33'h55;
        step();
        out_en = '0;
        check("multi_port", 64'(m_port), 64'd1);
        check("multi_data", 64'(m_data), 64'h55);
        check("multi_flag", 64'(multi_err), 64'd1);
        repeat (100) step();
        check("multi_sticky", 64'(multi_err), 64'd1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            out_en = 4'b0010;
            io_out = 33'h100 + 33'(i);
            step();
        end
        out_en = '0;
        check("pre_rst_count", 64'(count), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_empty", 64'(empty), 64'd1);
        check("async_valid", 64'(m_valid), 64'd0);
        check("async_multi", 64'(multi_err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        out_en = 4'b1000;
        io_out = 33'h1_0000_0077;
        step();
        out_en = '0;
        check("post_rst_data", 64'(m_data), 64'h1_0000_0077);
        check("post_rst_port", 64'(m_port), 64'd3);
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_ovf", 64'(ovf_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
